// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - run-time loadable instruction memory with handshaked registered fetch
// Loaded through a streaming port, then read by the fetch stage; out-of-program reads return HALT_WORD.

module imem_loadable #(
    parameter int                    DATA_WIDTH = 10,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(10'b0010000010)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_err,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_oob,
    output logic [ADDR_WIDTH:0]   prog_len
);

    localparam int                DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH:0]     r_ptr;
    logic                    r_load_err;
    logic                    r_fetch_valid;
    logic                    r_fetch_oob;
    logic [DATA_WIDTH-1:0]   r_fetch_data;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic w_load_acc;
    logic w_full;
    logic w_wr;
    logic w_fetch_acc;
    logic w_in_range;

    // load_start wins over a word presented in the same cycle
    assign w_load_acc  = load_valid & load_ready & ~load_start;
    assign w_full      = (r_ptr == FULL);
    assign w_wr        = w_load_acc & ~w_full;
    assign w_fetch_acc = fetch_req & fetch_ready;
    assign w_in_range  = ({1'b0, fetch_addr} < r_ptr);

    assign load_ready  = (r_state == S_LOAD);
    assign fetch_ready = (r_state != S_LOAD);
    assign load_err    = r_load_err;
    assign fetch_valid = r_fetch_valid;
    assign fetch_data  = r_fetch_data;
    assign fetch_oob   = r_fetch_oob;
    // The write pointer doubles as the program length
    assign prog_len    = r_ptr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: w_state_nxt = S_EMPTY;
            S_LOAD:  if (w_load_acc && load_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_EMPTY;
        endcase
        if (load_start) w_state_nxt = S_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_ptr      <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (load_start) begin
                r_ptr      <= '0;
                r_load_err <= 1'b0;
            end else if (w_load_acc) begin
                if (w_full) r_load_err <= 1'b1;
                else        r_ptr      <= r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_fetch_oob   <= 1'b0;
        end else if (w_fetch_acc) begin
            r_fetch_valid <= 1'b1;
            if (w_in_range) begin
                r_fetch_data <= r_mem[fetch_addr];
                r_fetch_oob  <= 1'b0;
            end else begin
                r_fetch_data <= HALT_WORD;
                r_fetch_oob  <= 1'b1;
            end
        end else begin
            r_fetch_valid <= 1'b0;
        end
    end

    // Array is deliberately not reset; prog_len alone gates reachability
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_ptr[ADDR_WIDTH-1:0]] <= load_data;
    end

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - scoreboard bench for imem_loadable (default and ADDR_WIDTH=2 instances)
module tb_imem_loadable;

    localparam logic [9:0] HALT = 10'b0010000010;

    typedef struct packed {
        logic       oob;
        logic [9:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_load_start = 0, a_load_valid = 0, a_load_last = 0, a_fetch_req = 0;
    logic [9:0] a_load_data = '0, a_fetch_addr = '0;
    logic       a_load_ready, a_load_err, a_fetch_ready, a_fetch_valid, a_fetch_oob;
    logic [9:0] a_fetch_data;
    logic [10:0] a_prog_len;

    logic       b_load_start = 0, b_load_valid = 0, b_load_last = 0, b_fetch_req = 0;
    logic [9:0] b_load_data = '0;
    logic [1:0] b_fetch_addr = '0;
    logic       b_load_ready, b_load_err, b_fetch_ready, b_fetch_valid, b_fetch_oob;
    logic [9:0] b_fetch_data;
    logic [2:0] b_prog_len;

    imem_loadable dut_a (
        .clk(clk), .rst_n(rst_n),
        .load_start(a_load_start), .load_valid(a_load_valid), .load_data(a_load_data),
        .load_last(a_load_last), .load_ready(a_load_ready), .load_err(a_load_err),
        .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr), .fetch_ready(a_fetch_ready),
        .fetch_valid(a_fetch_valid), .fetch_data(a_fetch_data), .fetch_oob(a_fetch_oob),
        .prog_len(a_prog_len)
    );

    imem_loadable #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
        .load_last(b_load_last), .load_ready(b_load_ready), .load_err(b_load_err),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_ready(b_fetch_ready),
        .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data), .fetch_oob(b_fetch_oob),
        .prog_len(b_prog_len)
    );

    exp_t        qa[$];
    exp_t        qb[$];
    string       cq_name[$];
    logic [31:0] cq_act[$];
    logic [31:0] cq_exp[$];
    int checks = 0;
    int errors = 0;
    int a_pops = 0;
    int b_pops = 0;
    bit done = 0;
    bit final_done = 0;

    // Monitor: sole owner of the check/error counters
    initial begin
        exp_t        e;
        string       n;
        logic [31:0] act, req;
        forever begin
            @(negedge clk);
            while (cq_name.size() > 0) begin
                n = cq_name.pop_front();
                act = cq_act.pop_front();
                req = cq_exp.pop_front();
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL %s: actual %0h required %0h", n, act, req);
                end
            end
            if (rst_n && a_fetch_valid) begin
                checks++;
                a_pops++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_resp: actual data %0h oob %0b required no response", a_fetch_data, a_fetch_oob);
                end else begin
                    e = qa.pop_front();
                    if ({a_fetch_oob, a_fetch_data} !== e) begin
                        errors++;
                        $display("FAIL a_fetch_resp: actual data %0h oob %0b required data %0h oob %0b",
                                 a_fetch_data, a_fetch_oob, e.data, e.oob);
                    end
                end
            end
            if (rst_n && b_fetch_valid) begin
                checks++;
                b_pops++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_resp: actual data %0h oob %0b required no response", b_fetch_data, b_fetch_oob);
                end else begin
                    e = qb.pop_front();
                    if ({b_fetch_oob, b_fetch_data} !== e) begin
                        errors++;
                        $display("FAIL b_fetch_resp: actual data %0h oob %0b required data %0h oob %0b",
                                 b_fetch_data, b_fetch_oob, e.data, e.oob);
                    end
                end
            end
            if (done && !final_done) begin
                final_done = 1;
                checks++;
                if (qa.size() + qb.size() != 0) begin
                    errors++;
                    $display("FAIL missing_responses: actual %0d outstanding required 0", qa.size() + qb.size());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] req);
        cq_name.push_back(name);
        cq_act.push_back(act);
        cq_exp.push_back(req);
    endtask

    task automatic start(input bit b);
        if (!b) a_load_start = 1; else b_load_start = 1;
        tick();
        a_load_start = 0;
        b_load_start = 0;
    endtask

    task automatic load_word(input bit b, input logic [9:0] d, input logic last);
        if (!b) begin a_load_valid = 1; a_load_data = d; a_load_last = last; end
        else    begin b_load_valid = 1; b_load_data = d; b_load_last = last; end
        tick();
        a_load_valid = 0; a_load_last = 0;
        b_load_valid = 0; b_load_last = 0;
    endtask

    // Consecutive calls keep fetch_req high across edges (back-to-back)
    task automatic fetch(input bit b, input int addr, input logic [9:0] ed, input logic eo);
        exp_t e;
        e.data = ed;
        e.oob  = eo;
        if (!b) begin a_fetch_req = 1; a_fetch_addr = 10'(addr); qa.push_back(e); end
        else    begin b_fetch_req = 1; b_fetch_addr = 2'(addr);  qb.push_back(e); end
        tick();
        a_fetch_req = 0;
        b_fetch_req = 0;
    endtask

    initial begin
        int pops0;
        repeat (2) tick();
        dchk("rst_prog_len", 32'(a_prog_len), 32'd0);
        dchk("rst_fetch_valid", 32'(a_fetch_valid), 32'd0);
        dchk("rst_fetch_data", 32'(a_fetch_data), 32'd0);
        dchk("rst_fetch_oob", 32'(a_fetch_oob), 32'd0);
        dchk("rst_load_err", 32'(a_load_err), 32'd0);
        dchk("rst_load_ready", 32'(a_load_ready), 32'd0);
        dchk("rst_fetch_ready", 32'(a_fetch_ready), 32'd1);
        dchk("rst_b_prog_len", 32'(b_prog_len), 32'd0);
        rst_n = 1;
        tick();

        fetch(0, 0, HALT, 1);
        dchk("empty_prog_len", 32'(a_prog_len), 32'd0);

        start(0);
        dchk("load_ready_in_load", 32'(a_load_ready), 32'd1);
        dchk("fetch_ready_in_load", 32'(a_fetch_ready), 32'd0);
        load_word(0, 10'b0000000001, 0);
        load_word(0, 10'b1101010000, 0);
        load_word(0, 10'b1101011001, 1);
        dchk("prog_len_3", 32'(a_prog_len), 32'd3);
        dchk("run_load_ready", 32'(a_load_ready), 32'd0);
        dchk("run_fetch_ready", 32'(a_fetch_ready), 32'd1);
        dchk("run_load_err", 32'(a_load_err), 32'd0);

        pops0 = a_pops;
        fetch(0, 0, 10'h001, 0);
        fetch(0, 1, 10'h350, 0);
        fetch(0, 2, 10'h359, 0);
        fetch(0, 3, HALT, 1);
        tick();
        dchk("b2b_resp_count", 32'(a_pops - pops0), 32'd4);
        dchk("idle_fetch_valid", 32'(a_fetch_valid), 32'd0);
        dchk("idle_hold_data", 32'(a_fetch_data), 32'(HALT));
        dchk("idle_hold_oob", 32'(a_fetch_oob), 32'd1);

        start(0);
        dchk("reload_fetch_ready", 32'(a_fetch_ready), 32'd0);
        a_fetch_req = 1;
        a_fetch_addr = 10'd0;
        tick();
        a_fetch_req = 0;
        dchk("load_fetch_ignored", 32'(a_fetch_valid), 32'd0);
        load_word(0, 10'h111, 0);
        load_word(0, 10'h222, 0);
        dchk("partial_prog_len", 32'(a_prog_len), 32'd2);
        start(0);
        dchk("restart_prog_len", 32'(a_prog_len), 32'd0);
        dchk("restart_load_ready", 32'(a_load_ready), 32'd1);
        load_word(0, 10'h3AB, 1);
        dchk("one_word_prog_len", 32'(a_prog_len), 32'd1);
        fetch(0, 0, 10'h3AB, 0);
        fetch(0, 1, HALT, 1);

        a_load_start = 1; a_load_valid = 1; a_load_data = 10'h155; a_load_last = 1;
        tick();
        a_load_start = 0; a_load_valid = 0; a_load_last = 0;
        dchk("start_valid_prog_len", 32'(a_prog_len), 32'd0);
        dchk("start_valid_load_ready", 32'(a_load_ready), 32'd1);
        load_word(0, 10'h0AA, 1);
        dchk("after_drop_prog_len", 32'(a_prog_len), 32'd1);
        fetch(0, 0, 10'h0AA, 0);
        tick();

        start(0);
        load_word(0, 10'h201, 0);
        load_word(0, 10'h202, 0);
        rst_n = 0;
        #1;
        dchk("async_prog_len", 32'(a_prog_len), 32'd0);
        dchk("async_load_ready", 32'(a_load_ready), 32'd0);
        dchk("async_fetch_ready", 32'(a_fetch_ready), 32'd1);
        dchk("async_fetch_data", 32'(a_fetch_data), 32'd0);
        dchk("async_fetch_oob", 32'(a_fetch_oob), 32'd0);
        tick();
        rst_n = 1;
        tick();
        fetch(0, 0, HALT, 1);
        dchk("post_rst_prog_len", 32'(a_prog_len), 32'd0);

        start(1);
        load_word(1, 10'h101, 0);
        load_word(1, 10'h102, 0);
        load_word(1, 10'h103, 0);
        load_word(1, 10'h104, 0);
        dchk("b_full_load_err", 32'(b_load_err), 32'd0);
        dchk("b_full_load_ready", 32'(b_load_ready), 32'd1);
        dchk("b_full_prog_len", 32'(b_prog_len), 32'd4);
        load_word(1, 10'h105, 1);
        dchk("b_ovf_load_err", 32'(b_load_err), 32'd1);
        dchk("b_ovf_prog_len", 32'(b_prog_len), 32'd4);
        dchk("b_ovf_run", 32'(b_load_ready), 32'd0);
        fetch(1, 0, 10'h101, 0);
        fetch(1, 3, 10'h104, 0);

        repeat (2) tick();
        done = 1;
        repeat (3) tick();
        if (!final_done) begin
            $display("FAIL monitor_final: actual not reached required reached");
            $fatal(1, "monitor did not complete");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed 10-bit instruction ROM.
- Instruction memory loaded at run time through a streaming load port, then read by the CPU fetch stage with a registered, handshaked read.
- Reads outside the loaded program return a configurable HALT word and raise a flag, so a runaway PC stops the core cleanly.
- Sits between the boot/test loader and the single-cycle CPU datapath.

Parameters:
DATA_WIDTH, 10, instruction word width in bits.
ADDR_WIDTH, 10, address width; memory depth is 2**ADDR_WIDTH.
HALT_WORD, 10'b0010000010, word returned for reads at or beyond the program length (sized to DATA_WIDTH).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
load_start  input  1  pulse: begin a new program load at address 0.
load_valid  input  1  load_data holds a valid word.
load_data  input  DATA_WIDTH  instruction word to store.
load_last  input  1  qualifies the final word of the program (sampled with load_valid).
load_ready  output  1  block accepts a load word this cycle.
load_err  output  1  sticky: a word was presented after memory was full.
fetch_req  input  1  read request.
fetch_addr  input  ADDR_WIDTH  word address to read.
fetch_ready  output  1  block accepts a fetch request this cycle.
fetch_valid  output  1  fetch_data is valid.
fetch_data  output  DATA_WIDTH  returned instruction word.
fetch_oob  output  1  returned word is HALT_WORD because the address is out of range.
prog_len  output  ADDR_WIDTH+1  number of words in the loaded program.

Behaviour:
- Reset (async assert, sync release): state=EMPTY, prog_len=0, load pointer=0, load_err=0, fetch_valid=0, fetch_data=0, fetch_oob=0. Memory array contents are not reset.
- State EMPTY:
  - load_ready=0, fetch_ready=1.
  - Every fetch returns HALT_WORD with fetch_oob=1.
- State LOAD (entered from any state on load_start; same cycle: pointer=0, prog_len=0, load_err=0):
  - load_ready=1, fetch_ready=0. Fetch requests are ignored; fetch_valid=0 the cycle after.
- LOAD word accept (load_valid & load_ready):
  - Write load_data to mem[pointer]; pointer++; prog_len=pointer+1.
  - If load_last is set, go to RUN next cycle.
- LOAD overflow: after 2**ADDR_WIDTH words, pointer saturates and load_ready stays 1.
  - Further valid words are dropped and load_err sets.
  - load_last still moves to RUN, with prog_len=2**ADDR_WIDTH.
- load_start with load_valid in the same cycle: the restart wins and the word is dropped.
- load_start while in LOAD: restarts the load. prog_len and pointer return to 0.
- State RUN: load_ready=0, fetch_ready=1.
- Fetch latency is 1 cycle. For a request accepted in cycle N:
  - fetch_valid=1 in cycle N+1.
  - fetch_data=mem[fetch_addr] if fetch_addr < prog_len, else HALT_WORD with fetch_oob=1.
  - Back-to-back requests produce back-to-back responses.
  - With no request, fetch_valid=0 and fetch_data/fetch_oob hold their last values.
- Comparisons are unsigned. prog_len is ADDR_WIDTH+1 bits so a full memory is representable.
- Reset mid-load: returns to EMPTY. Words already written stay in the array but are unreachable (prog_len=0).

Test Plan:
- Reset, then fetch addr 0 → next cycle fetch_valid=1, fetch_data=10'b0010000010, fetch_oob=1, prog_len=0.
- load_start; stream 10'b0000000001, 10'b1101010000, 10'b1101011001 (last) → prog_len=3, state RUN. Fetch 0,1,2,3 back-to-back → 0x001, 0x350, 0x359, then HALT with oob=1, on consecutive cycles.
- Fetch during LOAD → fetch_ready=0, no fetch_valid. load_start re-asserted after 2 words → prog_len=0; reload 1 word → prog_len=1.
- ADDR_WIDTH=2: load 5 words, last on the 5th → load_err=1, prog_len=4; fetch 3 returns the 4th word.
- rst_n low mid-load, after 2 words → outputs at reset values immediately (async); fetch 0 returns HALT.
- load_start and load_valid in the same cycle → word dropped, pointer=0, load_ready=1 next cycle.
